// File: rtl/dp_ram_bytewr.sv
// Simple dual-port RAM: port A writes with per-byte enables, port B reads with write-first
// collision forwarding and 1- or 2-cycle latency. Define DP_RAM_CLEAR_EN for the post-reset zero-fill.

module dp_ram_bytewr_lane #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int BW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  input  logic          fwd,
  output logic [BW-1:0] rdata
);
  logic [BW-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the clear sequencer owns zeroing.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = fwd ? wdata : mem_q[raddr];
endmodule

module dp_ram_bytewr #(
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dia,
  input  logic                             enb,
  input  logic [ADDR_WIDTH-1:0]            addrb,
  output logic [DATA_WIDTH-1:0]            dob,
  output logic                             dob_valid,
  output logic                             init_busy
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int STAGES    = (OUT_REG != 0) ? 2 : 1;
  // One spare bit so a power-of-two depth still fits the bound.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic                  clr_act;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef DP_RAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_e;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      if (cnt_q == LAST) state_d = S_READY;
      else               cnt_d   = cnt_q + 1'b1;
    end
  end

  assign clr_act  = (state_q == S_CLEAR);
  assign clr_addr = cnt_q;
`else
  assign clr_act  = 1'b0;
  assign clr_addr = '0;
`endif

  assign init_busy = clr_act;

  logic wr_ok, rd_fire, rd_in, collide;
  assign wr_ok   = ena & ~clr_act & ({1'b0, addra} < DEPTH_W);
  assign rd_fire = enb & ~clr_act;
  assign rd_in   = ({1'b0, addrb} < DEPTH_W);
  assign collide = wr_ok & rd_in & (addra == addrb);

  logic [NUM_BYTES-1:0]                 lane_we, lane_fwd;
  logic [ADDR_WIDTH-1:0]                lane_waddr;
  logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] dia_b, lane_wdata, lane_rdata;

  assign dia_b = dia;

  always_comb begin
    lane_we    = '0;
    lane_fwd   = '0;
    lane_wdata = '0;
    lane_waddr = clr_act ? clr_addr : addra;
    for (int i = 0; i < NUM_BYTES; i++) begin
      lane_we[i]    = clr_act | (wr_ok & wea[i]);
      lane_fwd[i]   = collide & wea[i];
      lane_wdata[i] = clr_act ? '0 : dia_b[i];
    end
  end

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    dp_ram_bytewr_lane #(
      .DEPTH (RAM_DEPTH),
      .AW    (ADDR_WIDTH),
      .BW    (BYTE_WIDTH)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .waddr (lane_waddr),
      .wdata (lane_wdata[i]),
      .raddr (addrb),
      .fwd   (lane_fwd[i]),
      .rdata (lane_rdata[i])
    );
  end

  logic [DATA_WIDTH-1:0] rd_word, last_src;
  assign rd_word = rd_in ? lane_rdata : '0;

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    always_comb begin
      s1_d = s1_q;
      if (rd_fire) s1_d = rd_word;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_q <= '0;
      else        s1_q <= s1_d;
    end
    assign last_src = s1_q;
  end else begin : g_noreg
    assign last_src = rd_word;
  end

  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0] dob_q, dob_d;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[1] = rd_fire;
    for (int k = 2; k <= STAGES; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    dob_d = vld_pipe_d[STAGES] ? last_src : dob_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      dob_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dob_q      <= dob_d;
    end
  end

  assign dob       = dob_q;
  assign dob_valid = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_dp_ram_bytewr.sv
// Randomised scoreboard bench: two instances (1- and 2-cycle read latency) share stimulus and
// are checked against a word-array model of the RAM. Honours DP_RAM_CLEAR_EN when defined.
module tb_dp_ram_bytewr;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0, enb = 1'b0;
  logic [7:0]       wea = '0;
  logic [AW-1:0]    addra = '0, addrb = '0;
  logic [63:0]      dia = '0;
  logic [1:0][63:0] dob;
  logic [1:0]       vld, busy;

  int          n_chk = 0, n_pass = 0, cyc = 0, n;
  exp_t        q [2][$];
  exp_t        mon_e;
  logic [63:0] last [2];
  logic [63:0] model [DEPTH];

  dp_ram_bytewr #(.RAM_DEPTH(DEPTH), .DATA_WIDTH(64), .BYTE_WIDTH(8), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dob[0]), .dob_valid(vld[0]), .init_busy(busy[0]));
  dp_ram_bytewr #(.RAM_DEPTH(DEPTH), .DATA_WIDTH(64), .BYTE_WIDTH(8), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dob[1]), .dob_valid(vld[1]), .init_busy(busy[1]));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Write-first: apply the write to the model, then the read sees the merged word.
  task automatic op(input logic a_en, input logic [7:0] a_we, input logic [AW-1:0] a_ad,
                    input logic [63:0] a_d, input logic b_en, input logic [AW-1:0] b_ad);
    exp_t e;
    @(posedge clk); #1;
    ena = a_en; wea = a_we; addra = a_ad; dia = a_d; enb = b_en; addrb = b_ad;
    if (a_en && int'(a_ad) < DEPTH)
      for (int b = 0; b < 8; b++) if (a_we[b]) model[a_ad][b*8 +: 8] = a_d[b*8 +: 8];
    if (b_en) begin
      e.data = (int'(b_ad) < DEPTH) ? model[b_ad] : 64'h0;
      e.cyc  = cyc + 1; q[0].push_back(e);
      e.cyc  = cyc + 2; q[1].push_back(e);
    end
  endtask

  task automatic idle();
    op(1'b0, 8'h00, '0, 64'h0, 1'b0, '0);
  endtask

  task automatic rand_op();
    logic [AW-1:0] a, b;
    a = AW'($urandom_range(0, 15));
    b = ($urandom_range(0, 2) == 0) ? a : AW'($urandom_range(0, 15));
    op($urandom_range(0, 1) == 1, 8'($urandom), a, {$urandom, $urandom},
       $urandom_range(0, 4) > 1, b);
  endtask

  task automatic sweep();
    for (int a = 0; a < 16; a++) op(1'b0, 8'h00, '0, 64'h0, 1'b1, AW'(a));
    idle();
  endtask

  // Release reset; with the sequencer, hammer both ports during CLEAR to prove they are ignored.
  task automatic release_rst();
    @(posedge clk); #1;
`ifdef DP_RAM_CLEAR_EN
    ena = 1'b1; wea = 8'hFF; addra = 4'd4; dia = {$urandom, $urandom}; enb = 1'b1; addrb = 4'd4;
    rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (busy[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", 64'(n), 64'(DEPTH));
    chk("u1_busy_after_clear", 64'(busy[1]), 64'h0);
    ena = 1'b0; enb = 1'b0; wea = '0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
`else
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_busy_tied", 64'(busy), 64'h0);
`endif
  endtask

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) last[i] = '0;
      else if (vld[i]) begin
        if (q[i].size() == 0) begin
          n_chk++;
          $display("FAIL u%0d_unexpected_valid: got dob_valid=1 dob=%h, expected no pending read", i, dob[i]);
        end else begin
          mon_e = q[i].pop_front();
          chk($sformatf("u%0d_dob", i), dob[i], mon_e.data);
          chk($sformatf("u%0d_latency", i), 64'(cyc), 64'(mon_e.cyc));
        end
        last[i] = dob[i];
      end else chk($sformatf("u%0d_hold", i), dob[i], last[i]);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_rst_dob", i), dob[i], 64'h0);
      chk($sformatf("u%0d_rst_valid", i), 64'(vld[i]), 64'h0);
`ifdef DP_RAM_CLEAR_EN
      chk($sformatf("u%0d_rst_busy", i), 64'(busy[i]), 64'h1);
`else
      chk($sformatf("u%0d_rst_busy", i), 64'(busy[i]), 64'h0);
`endif
    end
    release_rst();
`ifdef DP_RAM_CLEAR_EN
    sweep();
`endif
    for (int a = 0; a < DEPTH; a++) op(1'b1, 8'hFF, AW'(a), {$urandom, $urandom}, 1'b0, '0);
    op(1'b1, 8'hFF, 4'd5, 64'h0123456789ABCDEF, 1'b0, '0);
    op(1'b0, 8'h00, '0, 64'h0, 1'b1, 4'd5);
    op(1'b1, 8'hFF, 4'd3, 64'h1111111111111111, 1'b0, '0);
    op(1'b1, 8'h0F, 4'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0);
    op(1'b0, 8'h00, '0, 64'h0, 1'b1, 4'd3);
    op(1'b1, 8'hFF, 4'd7, 64'hAAAAAAAAAAAAAAAA, 1'b0, '0);
    op(1'b1, 8'hF0, 4'd7, 64'h5555555555555555, 1'b1, 4'd7);
    op(1'b1, 8'hFF, 4'd11, 64'hC0FFEE00DEADBEEF, 1'b0, '0);
    op(1'b1, 8'hFF, 4'd13, 64'h1234123412341234, 1'b1, 4'd13);
    op(1'b0, 8'h00, '0, 64'h0, 1'b1, 4'd13);
    op(1'b0, 8'h00, '0, 64'h0, 1'b1, 4'd11);
    idle();
    repeat (300) rand_op();
    idle();
    repeat (4) idle();

    // Reset in the middle of a burst of reads: everything in flight is discarded.
    op(1'b0, 8'h00, '0, 64'h0, 1'b1, 4'd1);
    @(posedge clk); #1;
    enb = 1'b1; addrb = 4'd2;
    #2;
    rst_n = 1'b0;
    q[0].delete(); q[1].delete();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_midrst_dob", i), dob[i], 64'h0);
      chk($sformatf("u%0d_midrst_valid", i), 64'(vld[i]), 64'h0);
    end
    @(posedge clk); #1;
    addrb = 4'd3;
    @(posedge clk); #1;
    enb = 1'b0;
    @(posedge clk);
    release_rst();
`ifdef DP_RAM_CLEAR_EN
    sweep();
`endif
    repeat (150) rand_op();
    sweep();

    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_q0", 64'(q[0].size()), 64'h0);
    chk("drain_q1", 64'(q[1].size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dp_ram_bytewr.md
Name: dp_ram_bytewr

Overview:
Parametrised simple dual-port block RAM: port A writes, port B reads. It is the successor to the team's 64-bit 16-entry buffer RAM and adds the following:
- per-byte write enables
- write-first forwarding on same-address collisions
- a selectable 1- or 2-cycle read latency with a valid strobe
- an optional post-reset clear sequencer
It is used as the weight/feature buffer between the DMA write side and the compute read side.

Parameters:
RAM_DEPTH, 16, number of words; any value >= 2, not required to be a power of two.
ADDR_WIDTH, $clog2(RAM_DEPTH), address width.
DATA_WIDTH, 64, word width; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  port A enable.
wea  input  NUM_BYTES  per-byte write enable; bit i controls dia[i*BYTE_WIDTH +: BYTE_WIDTH].
addra  input  ADDR_WIDTH  write address.
dia  input  DATA_WIDTH  write data.
enb  input  1  port B read request.
addrb  input  ADDR_WIDTH  read address.
dob  output  DATA_WIDTH  read data.
dob_valid  output  1  one-cycle strobe: dob holds the data for a request issued with enb.
init_busy  output  1  high while the clear sequencer runs; all port activity is ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dob=0, dob_valid=0, pipeline valid bits=0.
  - Clear counter=0. init_busy=1 if DP_RAM_CLEAR_EN, else 0.
  - Memory array is not reset by rst_n.
- FSM states: CLEAR -> READY.
  - CLEAR: on each cycle, write 0 to ram[cnt] and increment cnt. When cnt==RAM_DEPTH-1 has been written, go to READY; init_busy drops on the same edge.
  - CLEAR lasts exactly RAM_DEPTH cycles after rst_n rises.
  - READY: stays in READY until the next reset.
- Write (READY, ena=1): for each i with wea[i]=1, byte i of ram[addra] <= dia byte i. Other bytes are unchanged. ena=1 with wea=0 is a no-op.
- Read (READY, enb=1):
  - OUT_REG=0: dob and dob_valid are updated on the next edge.
  - OUT_REG=1: stage-1 register, then dob and dob_valid one edge later.
  - Back-to-back reads every cycle are supported (full throughput).
- dob holds its last value when no read completes. dob_valid=0 on those cycles.
- Collision (ena & enb & addra==addrb, same cycle): write-first. The returned word is the merge: bytes with wea=1 come from dia, all other bytes are the old contents.
- Out-of-range address (addr >= RAM_DEPTH):
  - Write is dropped.
  - Read completes with dob=0 and dob_valid=1.
  - No collision forwarding applies.
- During CLEAR: ena and enb are ignored, no dob_valid is produced, and dob stays 0.
- Reset mid-operation:
  - In-flight reads are discarded (dob_valid never asserts for them).
  - With DP_RAM_CLEAR_EN, the clear restarts from address 0.
- Storage array is sized exactly RAM_DEPTH entries (indices 0..RAM_DEPTH-1).

Optional Feature:
DP_RAM_CLEAR_EN
- Defined: the CLEAR state and counter are compiled in. Memory reads 0 everywhere after every reset, and ports are blocked for RAM_DEPTH cycles.
- Undefined: no sequencer. The FSM powers up in READY, init_busy is tied 0, and memory contents after reset are undefined (X in simulation). Ports are usable on the first edge after rst_n rises.

Test Plan:
1. CLEAR_EN on, DEPTH=16: release rst_n -> init_busy high for exactly 16 cycles. Then read addr 0..15 -> dob=0 each, with dob_valid high once per read.
2. OUT_REG=0: write 0x0123456789ABCDEF to addr 5 with wea=0xFF, then read addr 5 -> dob=0x0123456789ABCDEF one cycle after enb. With OUT_REG=1 -> two cycles after enb.
3. Byte enables: addr 3 holds 0x1111111111111111. Write dia=0xFFFFFFFFFFFFFFFF with wea=0x0F, then read addr 3 -> 0x11111111FFFFFFFF.
4. Collision: addr 7 holds 0xAAAA...AA. Same cycle: write 0x5555...55 with wea=0xF0, and read addr 7 -> dob=0x55555555AAAAAAAA.
5. DEPTH=12: write addr 13 (dropped), then read addr 13 -> dob=0 with dob_valid=1. Read addr 11 -> prior contents unchanged.
6. Continuous reads of addr 1,2,3 (enb high 3 cycles) with rst_n pulsed low on the 2nd cycle -> dob=0 and dob_valid=0 immediately. No stale valid after release, and CLEAR restarts.
